// File: rtl/osd_pkg.sv
// osd_pkg -- shared types, constants and helpers for the OSD command transmitter.
//
// Contents:
//   osd_op_e        request opcode (DISABLE / ENABLE / ENABLE_INFO / WRITE)
//   osd_state_e     transmitter FSM states
//   CMD_*           command byte constants
//   OSD_BUF_BYTES   size of the OSD character buffer in bytes
//   INFO_WORDS      number of parameter words sent after ENABLE_INFO
//   cmd_word()      builds the 16-bit CMD word for an opcode
//   info_word()     selects one zero-extended ENABLE_INFO parameter word
//   last_index()    last payload byte index of a WRITE after len fix-ups
package osd_pkg;

    typedef enum logic [1:0] {
        OP_DISABLE     = 2'd0,
        OP_ENABLE      = 2'd1,
        OP_ENABLE_INFO = 2'd2,
        OP_WRITE       = 2'd3
    } osd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PARAM,
        ST_DATA,
        ST_CLOSE,
        ST_GAP
    } osd_state_e;

    localparam logic [7:0] CMD_DISABLE     = 8'h40;
    localparam logic [7:0] CMD_ENABLE      = 8'h41;
    localparam logic [7:0] CMD_ENABLE_INFO = 8'h45;
    localparam logic [2:0] CMD_WRITE_PFX   = 3'b001;

    localparam int OSD_BUF_BYTES = 4096;
    localparam int INFO_WORDS    = 5;

    // The buffer holds 16 blocks of 256 bytes, so only the low four row
    // bits select a block inside the command byte.
    function automatic logic [15:0] cmd_word(input osd_op_e op,
                                             input logic highres,
                                             input logic [3:0] row);
        logic [7:0] c;
        case (op)
            OP_DISABLE:     c = CMD_DISABLE;
            OP_ENABLE:      c = CMD_ENABLE;
            OP_ENABLE_INFO: c = CMD_ENABLE_INFO;
            default:        c = {CMD_WRITE_PFX, highres, row};
        endcase
        return {8'h00, c};
    endfunction

    // info layout: {rot[1:0], infoh[5:0], infow[5:0], infoy[11:0], infox[11:0], pad[9:0]}
    function automatic logic [15:0] info_word(input logic [47:0] info,
                                              input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {4'h0, info[21:10]};
            3'd1:    w = {4'h0, info[33:22]};
            3'd2:    w = {10'h000, info[39:34]};
            3'd3:    w = {10'h000, info[45:40]};
            default: w = {14'h0000, info[47:46]};
        endcase
        return w;
    endfunction

    // A zero length is sent as one byte, and the count is cut so the write
    // never runs past the end of the buffer. A start row beyond the buffer
    // leaves no legal room, so only a single byte goes out.
    function automatic logic [11:0] last_index(input logic [4:0]  row,
                                               input logic [12:0] len);
        logic [12:0] n;
        logic [12:0] room;
        n = (len == 13'd0) ? 13'd1 : len;
        room = row[4] ? 13'd1 : (13'(OSD_BUF_BYTES) - {1'b0, row[3:0], 8'h00});
        if (n > room) begin
            n = room;
        end
        return 12'(n - 13'd1);
    endfunction

endpackage

// File: rtl/osd_cmd_tx_if.sv
// osd_cmd_tx_if -- request, payload-read and OSD io bus of the command transmitter.
//
// Signals:
//   req_valid/req_ready   request handshake (accepted when both high)
//   req_op, req_highres, req_row, req_len, req_info   request fields
//   rd_addr / rd_data     payload byte fetch (data one cycle after address)
//   io_osd, io_strobe, io_din   OSD io bus
//   busy                  transmitter not idle
// Modports:
//   master  the transmitter
//   slave   the requester / payload memory / OSD receiver side
interface osd_cmd_tx_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_highres;
    logic [4:0]  req_row;
    logic [12:0] req_len;
    logic [47:0] req_info;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;
    logic        busy;

    modport master (
        input  req_valid, req_op, req_highres, req_row, req_len, req_info, rd_data,
        output req_ready, rd_addr, io_osd, io_strobe, io_din, busy
    );

    modport slave (
        output req_valid, req_op, req_highres, req_row, req_len, req_info, rd_data,
        input  req_ready, rd_addr, io_osd, io_strobe, io_din, busy
    );
endinterface

// File: rtl/osd_strobe_gen.sv
// osd_strobe_gen -- word slot timer for the OSD io bus.
//
// A slot lasts STB_PERIOD cycles starting the cycle after slot_start:
// cycle 0 data setup, cycle 1 io_strobe high, remaining cycles idle.
// Ports:
//   clk_sys     clock
//   reset_n     asynchronous active-low reset
//   slot_start  begin a new slot next cycle (may coincide with slot_done)
//   io_strobe   strobe, high in slot cycle 1 only
//   slot_done   high in the last cycle of a running slot
module osd_strobe_gen #(
    parameter int STB_PERIOD = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic slot_start,
    output logic io_strobe,
    output logic slot_done
);

    localparam logic [3:0] LAST = 4'(STB_PERIOD - 1);

    logic [3:0] cnt;
    logic       active;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 4'd0;
            active <= 1'b0;
        end else if (slot_start) begin
            cnt    <= 4'd0;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == LAST) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Decoded from flops only, so reset clears the strobe immediately.
    assign io_strobe = active && (cnt == 4'd1);
    assign slot_done = active && (cnt == LAST);

endmodule

// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx -- sends DISABLE / ENABLE / ENABLE_INFO / WRITE transactions on
// the OSD io bus (io_osd frame, io_strobe word strobe, io_din word).
//
// Ports:
//   clk_sys   clock, all logic rising-edge
//   reset_n   asynchronous active-low reset
//   bus       osd_cmd_tx_if.master: request handshake, payload read port,
//             OSD io bus and busy flag
// Parameters:
//   STB_PERIOD  clk_sys cycles per io word (3..15)
//   GAP_CYC     idle cycles in GAP before the next request (1..15)
module osd_cmd_tx
    import osd_pkg::*;
#(
    parameter int STB_PERIOD = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    osd_cmd_tx_if.master bus
);

    osd_state_e  state_q, state_n;
    osd_op_e     op_q, op_n;
    logic [47:0] info_q, info_n;
    logic [11:0] last_idx_q, last_idx_n;
    logic [11:0] word_idx_q, word_idx_n;
    logic [3:0]  gap_cnt_q, gap_cnt_n;
    logic        io_osd_q, io_osd_n;
    logic [15:0] io_din_q, io_din_n;
    logic [11:0] rd_addr_q, rd_addr_n;
    logic        rst_done_q;

    logic        slot_start;
    logic        slot_done;
    logic        strobe;
    logic        req_ready;
    logic [11:0] next_idx;

    osd_strobe_gen #(.STB_PERIOD(STB_PERIOD)) u_strobe (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .slot_start (slot_start),
        .io_strobe  (strobe),
        .slot_done  (slot_done)
    );

    // rst_done_q keeps req_ready low while reset is held and for the cycle
    // of release; it rises on the first clock afterwards.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_DISABLE;
            info_q     <= 48'd0;
            last_idx_q <= 12'd0;
            word_idx_q <= 12'd0;
            gap_cnt_q  <= 4'd0;
            io_osd_q   <= 1'b0;
            io_din_q   <= 16'd0;
            rd_addr_q  <= 12'd0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            op_q       <= op_n;
            info_q     <= info_n;
            last_idx_q <= last_idx_n;
            word_idx_q <= word_idx_n;
            gap_cnt_q  <= gap_cnt_n;
            io_osd_q   <= io_osd_n;
            io_din_q   <= io_din_n;
            rd_addr_q  <= rd_addr_n;
            rst_done_q <= 1'b1;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && rst_done_q;
    assign next_idx  = (state_q == ST_DATA) ? (word_idx_q + 12'd1) : 12'd0;

    // Each new word is loaded into io_din on the edge that ends the previous
    // slot, together with slot_start. For payload words rd_addr already
    // points one word ahead for the whole slot, so rd_data has settled long
    // before it is captured; on the last word rd_addr stays put (no wrap).
    always_comb begin
        state_n    = state_q;
        op_n       = op_q;
        info_n     = info_q;
        last_idx_n = last_idx_q;
        word_idx_n = word_idx_q;
        gap_cnt_n  = gap_cnt_q;
        io_osd_n   = io_osd_q;
        io_din_n   = io_din_q;
        rd_addr_n  = rd_addr_q;
        slot_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    state_n    = ST_CMD;
                    op_n       = osd_op_e'(bus.req_op);
                    info_n     = bus.req_info;
                    last_idx_n = last_index(bus.req_row, bus.req_len);
                    word_idx_n = 12'd0;
                    io_osd_n   = 1'b1;
                    io_din_n   = cmd_word(osd_op_e'(bus.req_op), bus.req_highres,
                                          bus.req_row[3:0]);
                    rd_addr_n  = 12'd0;
                    slot_start = 1'b1;
                end
            end

            ST_CMD: begin
                if (slot_done) begin
                    case (op_q)
                        OP_ENABLE_INFO: begin
                            state_n    = ST_PARAM;
                            word_idx_n = 12'd0;
                            io_din_n   = info_word(info_q, 3'd0);
                            slot_start = 1'b1;
                        end
                        OP_WRITE: begin
                            state_n    = ST_DATA;
                            word_idx_n = next_idx;
                            io_din_n   = {8'h00, bus.rd_data};
                            rd_addr_n  = (next_idx != last_idx_q) ? next_idx + 12'd1 : next_idx;
                            slot_start = 1'b1;
                        end
                        default: begin
                            state_n  = ST_CLOSE;
                            io_osd_n = 1'b0;
                        end
                    endcase
                end
            end

            ST_PARAM: begin
                if (slot_done) begin
                    if (word_idx_q == 12'(INFO_WORDS - 1)) begin
                        state_n  = ST_CLOSE;
                        io_osd_n = 1'b0;
                    end else begin
                        word_idx_n = word_idx_q + 12'd1;
                        io_din_n   = info_word(info_q, word_idx_q[2:0] + 3'd1);
                        slot_start = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (slot_done) begin
                    if (word_idx_q == last_idx_q) begin
                        state_n  = ST_CLOSE;
                        io_osd_n = 1'b0;
                    end else begin
                        word_idx_n = next_idx;
                        io_din_n   = {8'h00, bus.rd_data};
                        rd_addr_n  = (next_idx != last_idx_q) ? next_idx + 12'd1 : next_idx;
                        slot_start = 1'b1;
                    end
                end
            end

            ST_CLOSE: begin
                state_n   = ST_GAP;
                gap_cnt_n = 4'd0;
            end

            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYC - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.io_osd    = io_osd_q;
    assign bus.io_strobe = strobe;
    assign bus.io_din    = io_din_q;
    assign bus.rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_osd_cmd_tx.sv
// tb_osd_cmd_tx -- directed self-checking bench for osd_cmd_tx
// (STB_PERIOD=4, GAP_CYC=2). A negedge monitor logs every strobed io_din
// word and each new rd_addr value seen while busy, and counts protocol
// violations (strobe with io_osd low, strobes on consecutive cycles).
module tb_osd_cmd_tx;
    import osd_pkg::*;

    localparam int STB = 4;
    localparam int GAP = 2;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    osd_cmd_tx_if bus ();

    osd_cmd_tx #(.STB_PERIOD(STB), .GAP_CYC(GAP)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Payload memory: one-cycle read latency, byte = addr + 0xA0.
    always @(posedge clk_sys) begin
        bus.rd_data <= bus.rd_addr[7:0] + 8'hA0;
    end

    logic [15:0] strobe_log[$];
    logic [11:0] addr_log[$];
    int          osd_low_strobes = 0;
    int          double_strobes  = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_busy   = 1'b0;
    logic [11:0] prev_addr   = 12'd0;

    always @(negedge clk_sys) begin
        if (bus.io_strobe) begin
            strobe_log.push_back(bus.io_din);
            if (!bus.io_osd) osd_low_strobes <= osd_low_strobes + 1;
            if (prev_strobe) double_strobes <= double_strobes + 1;
        end
        if (bus.busy && (!prev_busy || bus.rd_addr != prev_addr)) begin
            addr_log.push_back(bus.rd_addr);
        end
        prev_strobe <= bus.io_strobe;
        prev_busy   <= bus.busy;
        prev_addr   <= bus.rd_addr;
    end

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single clock, then scrambles every field
    // so a transmitter that fails to latch them is caught.
    task automatic applyStimulus(input logic [1:0] op, input logic hr,
                                 input logic [4:0] row, input logic [12:0] len,
                                 input logic [47:0] info);
        bus.req_op      = op;
        bus.req_highres = hr;
        bus.req_row     = row;
        bus.req_len     = len;
        bus.req_info    = info;
        bus.req_valid   = 1'b1;
        @(negedge clk_sys);
        bus.req_valid   = 1'b0;
        bus.req_op      = ~op;
        bus.req_highres = ~hr;
        bus.req_row     = ~row;
        bus.req_len     = 13'd7;
        bus.req_info    = ~info;
    endtask

    // Counts clocks since the request was presented until req_ready returns.
    task automatic waitReady(output int cycles);
        cycles = 1;
        while (!bus.req_ready && cycles < 3000) begin
            @(negedge clk_sys);
            cycles++;
        end
    endtask

    function automatic int txnCycles(input int words);
        return 1 + words * STB + 1 + GAP;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc;
        int          base;
        int          abase;
        int          n;
        int          rises;
        int          low_busy;
        int          at_reset;
        logic        prev_osd;
        logic [47:0] info;

        bus.req_valid   = 1'b0;
        bus.req_op      = 2'd0;
        bus.req_highres = 1'b0;
        bus.req_row     = 5'd0;
        bus.req_len     = 13'd0;
        bus.req_info    = 48'd0;

        // ---- reset state ----
        repeat (2) @(negedge clk_sys);
        checkOutput("rst_ready",  32'(bus.req_ready), 32'd0);
        checkOutput("rst_osd",    32'(bus.io_osd),    32'd0);
        checkOutput("rst_strobe", 32'(bus.io_strobe), 32'd0);
        checkOutput("rst_din",    32'(bus.io_din),    32'd0);
        checkOutput("rst_addr",   32'(bus.rd_addr),   32'd0);
        checkOutput("rst_busy",   32'(bus.busy),      32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("release_ready_early", 32'(bus.req_ready), 32'd0);
        @(negedge clk_sys);
        checkOutput("release_ready", 32'(bus.req_ready), 32'd1);

        // ---- DISABLE ----
        base = strobe_log.size();
        applyStimulus(2'd0, 1'b0, 5'd0, 13'd1, 48'd0);
        checkOutput("dis_osd_high", 32'(bus.io_osd), 32'd1);
        checkOutput("dis_busy",     32'(bus.busy),   32'd1);
        waitReady(cyc);
        checkOutput("dis_cycles",  32'(cyc), 32'd8);
        checkOutput("dis_strobes", 32'(strobe_log.size() - base), 32'd1);
        checkOutput("dis_word",    32'(strobe_log[base]), 32'h0040);
        checkOutput("dis_osd_end", 32'(bus.io_osd), 32'd0);

        // ---- ENABLE_INFO ----
        info = {2'd1, 6'd16, 6'd32, 12'd50, 12'd100, 10'd0};
        base = strobe_log.size();
        applyStimulus(2'd2, 1'b0, 5'd0, 13'd1, info);
        waitReady(cyc);
        checkOutput("info_cycles",  32'(cyc), 32'(txnCycles(6)));
        checkOutput("info_strobes", 32'(strobe_log.size() - base), 32'd6);
        checkOutput("info_w0", 32'(strobe_log[base]),     32'h0045);
        checkOutput("info_w1", 32'(strobe_log[base + 1]), 32'h0064);
        checkOutput("info_w2", 32'(strobe_log[base + 2]), 32'h0032);
        checkOutput("info_w3", 32'(strobe_log[base + 3]), 32'h0020);
        checkOutput("info_w4", 32'(strobe_log[base + 4]), 32'h0010);
        checkOutput("info_w5", 32'(strobe_log[base + 5]), 32'h0001);

        // ---- WRITE row=2 highres=1 len=3 ----
        base  = strobe_log.size();
        abase = addr_log.size();
        applyStimulus(2'd3, 1'b1, 5'd2, 13'd3, 48'd0);
        waitReady(cyc);
        checkOutput("wr_cycles",  32'(cyc), 32'(txnCycles(4)));
        checkOutput("wr_strobes", 32'(strobe_log.size() - base), 32'd4);
        checkOutput("wr_cmd", 32'(strobe_log[base]), 32'({8'h00, 3'b001, 1'b1, 4'd2}));
        checkOutput("wr_d0",  32'(strobe_log[base + 1]), 32'h00A0);
        checkOutput("wr_d1",  32'(strobe_log[base + 2]), 32'h00A1);
        checkOutput("wr_d2",  32'(strobe_log[base + 3]), 32'h00A2);
        checkOutput("wr_addr_count", 32'(addr_log.size() - abase), 32'd3);
        checkOutput("wr_addr0", 32'(addr_log[abase]),     32'd0);
        checkOutput("wr_addr1", 32'(addr_log[abase + 1]), 32'd1);
        checkOutput("wr_addr2", 32'(addr_log[abase + 2]), 32'd2);

        // ---- WRITE row=15 len=4096: clamped to 256 bytes ----
        base  = strobe_log.size();
        abase = addr_log.size();
        applyStimulus(2'd3, 1'b0, 5'd15, 13'd4096, 48'd0);
        waitReady(cyc);
        checkOutput("clamp_cycles",  32'(cyc), 32'(txnCycles(257)));
        checkOutput("clamp_strobes", 32'(strobe_log.size() - base), 32'd257);
        checkOutput("clamp_cmd",   32'(strobe_log[base]),       32'h002F);
        checkOutput("clamp_first", 32'(strobe_log[base + 1]),   32'h00A0);
        checkOutput("clamp_last",  32'(strobe_log[base + 256]), 32'h009F);
        checkOutput("clamp_addrs", 32'(addr_log.size() - abase), 32'd256);
        checkOutput("clamp_addr_hold", 32'(bus.rd_addr), 32'd255);

        // ---- reset during the 10th data slot ----
        base = strobe_log.size();
        applyStimulus(2'd3, 1'b0, 5'd0, 13'd20, 48'd0);
        n = 0;
        while (strobe_log.size() < base + 11 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        at_reset = strobe_log.size() - base;
        checkOutput("abort_strobes_before", 32'(at_reset), 32'd11);
        checkOutput("abort_word9", 32'(strobe_log[base + 10]), 32'h00A9);
        checkOutput("abort_osd",    32'(bus.io_osd),    32'd0);
        checkOutput("abort_strobe", 32'(bus.io_strobe), 32'd0);
        checkOutput("abort_busy",   32'(bus.busy),      32'd0);
        checkOutput("abort_ready",  32'(bus.req_ready), 32'd0);
        checkOutput("abort_din",    32'(bus.io_din),    32'd0);
        checkOutput("abort_addr",   32'(bus.rd_addr),   32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        #1;
        checkOutput("abort_release_early", 32'(bus.req_ready), 32'd0);
        @(negedge clk_sys);
        checkOutput("abort_release_ready", 32'(bus.req_ready), 32'd1);
        repeat (20) @(negedge clk_sys);
        checkOutput("abort_no_more_strobes", 32'(strobe_log.size() - base), 32'(at_reset));

        // ---- back-to-back ENABLE with req_valid held ----
        base = strobe_log.size();
        bus.req_op    = 2'd1;
        bus.req_valid = 1'b1;
        n        = 0;
        rises    = 0;
        low_busy = 0;
        prev_osd = 1'b0;
        while (n < 60) begin
            @(negedge clk_sys);
            n++;
            if (bus.io_osd && !prev_osd) begin
                rises++;
                if (rises == 2) bus.req_valid = 1'b0;
            end
            if (rises == 1 && !bus.io_osd && bus.busy) low_busy++;
            if (rises == 2 && bus.req_ready) break;
            prev_osd = bus.io_osd;
        end
        bus.req_valid = 1'b0;
        checkOutput("b2b_rises",    32'(rises),    32'd2);
        checkOutput("b2b_low_busy", 32'(low_busy), 32'(1 + GAP));
        checkOutput("b2b_cycles",   32'(n),        32'(2 * txnCycles(1)));
        checkOutput("b2b_strobes",  32'(strobe_log.size() - base), 32'd2);
        checkOutput("b2b_w0", 32'(strobe_log[base]),     32'h0041);
        checkOutput("b2b_w1", 32'(strobe_log[base + 1]), 32'h0041);

        // ---- protocol monitors ----
        checkOutput("strobe_without_osd",  32'(osd_low_strobes), 32'd0);
        checkOutput("consecutive_strobes", 32'(double_strobes),  32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
